// File: rtl/activation_timer_if.sv
// Control/status bundle between the array controller, the activation timer
// and the activation unit / output SRAM write logic.
interface activation_timer_if #(
   parameter int IDX_W = 2
);
   logic             start;
   logic             stall;
   logic             clear;
   logic             act_en;
   logic [IDX_W-1:0] row_idx;
   logic             out_valid;
   logic [IDX_W-1:0] out_row;
   logic             busy;
   logic             done;

   modport master (
      output start, stall, clear,
      input  act_en, row_idx, out_valid, out_row, busy, done
   );

   modport slave (
      input  start, stall, clear,
      output act_en, row_idx, out_valid, out_row, busy, done
   );
endinterface

// File: rtl/activation_timer.sv
// Paces the activation stage: issues ROWS row enables per job, tracks them
// through a LATENCY-deep pipeline and pulses done once the last row drains.
module activation_timer #(
   parameter  int ROWS    = 4,
   parameter  int LATENCY = 2,
   localparam int IDX_W   = $clog2(ROWS)
) (
   input logic               clk,
   input logic               n_rst,
   activation_timer_if.slave bus
);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_row_idx, w_row_idx_nxt;
   logic [CNT_W-1:0] r_drain_cnt, w_drain_cnt_nxt;
   logic             w_act_en;

   // The last stage doubles as the registered out_valid/out_row.
   logic [LATENCY-1:0] r_pipe_vld;
   logic [IDX_W-1:0]   r_pipe_idx [LATENCY];

   assign w_act_en      = (r_state == ISSUE) && !bus.stall;
   assign bus.act_en    = w_act_en;
   assign bus.row_idx   = r_row_idx;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == DONE);
   assign bus.out_valid = r_pipe_vld[LATENCY-1];
   assign bus.out_row   = r_pipe_idx[LATENCY-1];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= IDLE;
         r_row_idx   <= '0;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_row_idx   <= w_row_idx_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_row_idx_nxt   = r_row_idx;
      w_drain_cnt_nxt = r_drain_cnt;
      if (bus.clear) begin
         w_state_nxt     = IDLE;
         w_row_idx_nxt   = '0;
         w_drain_cnt_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  w_state_nxt   = ISSUE;
                  w_row_idx_nxt = '0;
               end
            end
            ISSUE: begin
               if (!bus.stall) begin
                  if (r_row_idx == IDX_W'(ROWS - 1)) begin
                     w_state_nxt     = DRAIN;
                     w_row_idx_nxt   = '0;
                     w_drain_cnt_nxt = '0;
                  end else begin
                     w_row_idx_nxt = r_row_idx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (!bus.stall) begin
                  if (r_drain_cnt == CNT_W'(LATENCY - 1)) begin
                     w_state_nxt     = DONE;
                     w_drain_cnt_nxt = '0;
                  end else begin
                     w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                  end
               end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < LATENCY; i++) r_pipe_idx[i] <= '0;
      end else if (bus.clear) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < LATENCY; i++) r_pipe_idx[i] <= '0;
      end else if (!bus.stall) begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_idx[i] <= r_pipe_idx[i-1];
         end
         r_pipe_vld[0] <= w_act_en;
         r_pipe_idx[0] <= r_row_idx;
      end
   end
endmodule

// File: tb/tb_activation_timer.sv
// Directed bench for activation_timer (ROWS=4, LATENCY=2) with an
// event scoreboard for act_en, out_valid and done.
module tb_activation_timer;
   logic clk = 1'b0;
   logic n_rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   base;

   typedef struct {int c; int row;} ev_t;
   ev_t q_act[$];
   ev_t q_out[$];
   int  q_done[$];
   ev_t m_e;
   int  m_d;

   activation_timer_if #(.IDX_W(2)) bus ();

   activation_timer #(.ROWS(4), .LATENCY(2)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input int val);
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected event value %0d, expected none (cyc %0d)", name, val, cyc);
   endtask

   function automatic int all_outs();
      return int'({bus.act_en, bus.busy, bus.out_valid, bus.done, bus.row_idx, bus.out_row});
   endfunction

   // Monitor: pops and compares on every presented output event.
   always @(negedge clk) begin
      if (bus.act_en) begin
         if (q_act.size() == 0) unexpected("act_en", int'(bus.row_idx));
         else begin
            m_e = q_act.pop_front();
            check("act_cyc", cyc, m_e.c);
            check("act_row", int'(bus.row_idx), m_e.row);
         end
      end
      if (bus.out_valid) begin
         if (q_out.size() == 0) unexpected("out_valid", int'(bus.out_row));
         else begin
            m_e = q_out.pop_front();
            check("out_cyc", cyc, m_e.c);
            check("out_row", int'(bus.out_row), m_e.row);
         end
      end
      if (bus.done) begin
         if (q_done.size() == 0) unexpected("done", cyc);
         else begin
            m_d = q_done.pop_front();
            check("done_cyc", cyc, m_d);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_nominal(input int b);
      for (int r = 0; r < 4; r++) begin
         q_act.push_back('{b + 1 + r, r});
         q_out.push_back('{b + 3 + r, r});
      end
      q_done.push_back(b + 7);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_act_left"}, q_act.size(), 0);
      check({tag, "_out_left"}, q_out.size(), 0);
      check({tag, "_done_left"}, q_done.size(), 0);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   initial begin
      n_rst     = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      bus.clear = 1'b0;

      repeat (2) begin
         @(negedge clk);
         check("rst_held_outs", all_outs(), 0);
      end
      tick(1);
      n_rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_outs", all_outs(), 0);
      end
      tick(1);

      // Nominal job.
      base = cyc;
      push_nominal(base);
      pulse_start();
      tick(6);
      @(negedge clk);
      check("nom_busy_c7", int'(bus.busy), 1);
      tick(1);
      @(negedge clk);
      check("nom_busy_c8", int'(bus.busy), 0);
      tick(3);
      check_drained("nom");

      // Two-cycle stall during row 1.
      base = cyc;
      q_act.push_back('{base + 1, 0});
      for (int r = 1; r < 4; r++) q_act.push_back('{base + 3 + r, r});
      for (int r = 0; r < 4; r++) q_out.push_back('{base + 5 + r, r});
      q_done.push_back(base + 9);
      pulse_start();
      tick(1);
      bus.stall = 1'b1;
      @(negedge clk);
      check("stall_row_c2", int'(bus.row_idx), 1);
      check("stall_act_c2", int'(bus.act_en), 0);
      tick(1);
      @(negedge clk);
      check("stall_row_c3", int'(bus.row_idx), 1);
      check("stall_oval_c3", int'(bus.out_valid), 0);
      tick(1);
      bus.stall = 1'b0;
      tick(8);
      check_drained("stall");

      // Clear in DRAIN: row 3 is flushed and no done.
      base = cyc;
      for (int r = 0; r < 4; r++) q_act.push_back('{base + 1 + r, r});
      for (int r = 0; r < 3; r++) q_out.push_back('{base + 3 + r, r});
      pulse_start();
      tick(4);
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      @(negedge clk);
      check("clr_busy_c6", int'(bus.busy), 0);
      check("clr_oval_c6", int'(bus.out_valid), 0);
      tick(6);
      check_drained("clear");

      base = cyc;
      push_nominal(base);
      pulse_start();
      tick(9);
      check_drained("after_clr");

      // Clear and start together in IDLE.
      bus.clear = 1'b1;
      bus.start = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check("clr_start_busy", int'(bus.busy), 0);
      tick(3);
      check_drained("clr_start");

      // Start while busy is ignored.
      base = cyc;
      push_nominal(base);
      pulse_start();
      tick(1);
      pulse_start();
      tick(8);
      check_drained("start_busy");

      // Asynchronous reset mid-ISSUE.
      base = cyc;
      q_act.push_back('{base + 1, 0});
      pulse_start();
      tick(1);
      #2;
      n_rst = 1'b0;
      #1;
      check("async_rst_outs", all_outs(), 0);
      tick(2);
      n_rst = 1'b1;
      tick(10);
      check("async_rel_busy", int'(bus.busy), 0);
      check_drained("async_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/activation_timer.md
Name: activation_timer

Overview:
- Sequencer that paces the activation-function stage behind the systolic array output rows.
- On a start pulse it issues one activation enable per output row, ROWS rows in total.
- It tracks a fixed-latency activation pipeline, flags each row leaving that pipeline, and pulses done when the last row has drained.
- Sits between the array controller (start/stall/clear) and the activation unit / output SRAM write logic.

Parameters:
- ROWS, 4, number of output rows issued per job (>=2).
- LATENCY, 2, activation pipeline depth in cycles (>=1).
- IDX_W, $clog2(ROWS), width of the row index outputs (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  job start request; sampled only in IDLE.
- stall  input  1  freeze; holds state, counters and pipeline for the cycle.
- clear  input  1  synchronous abort; returns to IDLE and flushes the pipeline.
- act_en  output  1  activation enable for row row_idx this cycle.
- row_idx  output  IDX_W  row currently being issued.
- out_valid  output  1  the row out_row is leaving the activation pipeline this cycle.
- out_row  output  IDX_W  row index carried through the pipeline with out_valid.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle job-complete pulse.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE; row_idx=0; pipeline valid and index stages cleared.
  - All outputs 0 immediately and for as long as reset is held.
  - Reset mid-job abandons the job with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 at a rising edge moves to ISSUE and sets row_idx=0.
  - start is ignored in every other state; no queueing.
- ISSUE:
  - act_en = (state==ISSUE) && !stall; combinational from registered state.
  - Each non-stalled cycle, row_idx's value enters pipeline stage 0 as valid and row_idx increments.
  - A non-stalled cycle with row_idx==ROWS-1 moves to DRAIN; row_idx wraps to 0.
- DRAIN:
  - A drain counter increments on each non-stalled cycle.
  - After LATENCY non-stalled DRAIN cycles, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally; stall is ignored in DONE.
- Pipeline:
  - LATENCY-stage shift register of {valid, index}; shifts only on non-stalled cycles.
  - Stage 0 loads act_en/row_idx; bubbles (valid=0) are inserted in non-ISSUE or stalled cycles.
  - out_valid and out_row are registered from the last stage.
  - A row issued in cycle t with no stalls appears on out_valid at cycle t+LATENCY.
- stall:
  - Holds state, row_idx, drain counter and pipeline contents.
  - act_en=0 while stalled; out_valid/out_row hold their registered values.
- clear:
  - Synchronous; highest priority over start and stall.
  - Next cycle: state=IDLE, row_idx=0, pipeline flushed (out_valid=0), no done pulse.
- Simultaneous events:
  - clear and start in IDLE: clear wins, stay IDLE.
  - stall in the cycle that would leave ISSUE or DRAIN: the transition is deferred.
- Timing with no stalls (start sampled at edge 0):
  - busy and act_en high cycles 1..ROWS.
  - out_valid high cycles 1+LATENCY..ROWS+LATENCY.
  - done at cycle ROWS+LATENCY+1; busy falls the following cycle.

Test Plan:
- Reset: hold n_rst=0 for 2 cycles, then release with start=0 -> all outputs 0, busy=0 for 2 further cycles.
- Nominal job (ROWS=4, LATENCY=2), start pulse at edge 0:
  - act_en high cycles 1-4 with row_idx 0,1,2,3.
  - out_valid high cycles 3-6 with out_row 0,1,2,3.
  - done=1 only at cycle 7; busy high cycles 1-7.
- Stall:
  - Stall high 2 cycles during row 1 issue -> act_en low those cycles, row_idx holds at 1, out_valid frozen.
  - Rows still emerge in order 0-3; done is delayed by exactly 2 cycles, at cycle 9.
- Clear: assert clear in DRAIN (cycle 5) -> cycle 6 state IDLE, out_valid=0, busy=0, done never asserted; a new start then runs a full job normally.
- Start while busy: pulse start at cycle 2 of a running job -> ignored; exactly 4 act_en cycles and 1 done pulse.
- Async reset mid-ISSUE: drop n_rst at cycle 2 between clock edges -> outputs go 0 without waiting for a clock edge; no done after release.
